// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the TDC coarse-time measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} tdc_state_t;

  localparam int TDC_CNT_W = 32;

endpackage

// File: rtl/tdc_delta.sv
// tdc_delta: wrap-safe coarse interval count - start_cnt, plus the optional timeout compare.
// Latency: purely combinational.
// Backpressure: none, no handshake.
// Ports: count/start_cnt in, delta out; timed_out out only when TDC_TIMEOUT_EN is defined.
module tdc_delta
  import tdc_pkg::*;
#(
  parameter int CNT_W = TDC_CNT_W
`ifdef TDC_TIMEOUT_EN
  , parameter logic [CNT_W-1:0] TIMEOUT = 32'd1_000_000
`endif
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] delta
`ifdef TDC_TIMEOUT_EN
  , output logic           timed_out
`endif
);

  // Modulo-2^CNT_W difference: a counter wrap between start and now still
  // yields the true elapsed count because the carry is simply dropped.
  assign delta = count - start_cnt;

`ifdef TDC_TIMEOUT_EN
  assign timed_out = (delta >= TIMEOUT);
`endif

endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: arm/start/stop sequencer for the TDC coarse counter, produces stop - start interval.
// Latency: cnt_clear 1 cycle after arm; result_valid 1 cycle after the stop_hit sample.
// Backpressure: result/result_valid/timeout_flag held in DONE until result_ready; arm and hits ignored there.
// Ports: clk, reset (async, active-high); arm, start_hit, stop_hit, count in; cnt_clear, busy out;
//        result, result_valid out / result_ready in (valid/ready); timeout_flag out.
// Build option: define TDC_TIMEOUT_EN to enable the RUN timeout (TIMEOUT cycles) and timeout_flag.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int CNT_W = TDC_CNT_W
`ifdef TDC_TIMEOUT_EN
  , parameter logic [CNT_W-1:0] TIMEOUT = 32'd1_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             start_hit,
  input  logic             stop_hit,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_clear,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_flag
);

  tdc_state_t       state, state_nxt;
  logic [CNT_W-1:0] start_cnt, start_cnt_nxt;
  logic [CNT_W-1:0] result_nxt;
  logic [CNT_W-1:0] delta;
  logic             cnt_clear_nxt;
  logic             result_valid_nxt;
`ifdef TDC_TIMEOUT_EN
  logic             timed_out;
  logic             timeout_flag_nxt;
`endif

  tdc_delta #(
    .CNT_W   (CNT_W)
`ifdef TDC_TIMEOUT_EN
    , .TIMEOUT (TIMEOUT)
`endif
  ) u_delta (
    .count     (count),
    .start_cnt (start_cnt),
    .delta     (delta)
`ifdef TDC_TIMEOUT_EN
    , .timed_out (timed_out)
`endif
  );

  always_comb begin
    state_nxt        = state;
    start_cnt_nxt    = start_cnt;
    result_nxt       = result;
    result_valid_nxt = result_valid;
    cnt_clear_nxt    = 1'b0;
`ifdef TDC_TIMEOUT_EN
    timeout_flag_nxt = timeout_flag;
`endif
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt     = ARMED;
          cnt_clear_nxt = 1'b1;
        end
      end
      ARMED: begin
        // A stop arriving with the start is discarded: only start is looked at here.
        if (start_hit) begin
          start_cnt_nxt = count;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        // stop_hit has priority over a timeout in the same cycle.
        if (stop_hit) begin
          result_nxt       = delta;
          result_valid_nxt = 1'b1;
          state_nxt        = DONE;
        end
`ifdef TDC_TIMEOUT_EN
        else if (timed_out) begin
          result_nxt       = '1;
          result_valid_nxt = 1'b1;
          timeout_flag_nxt = 1'b1;
          state_nxt        = DONE;
        end
`endif
      end
      DONE: begin
        // result_valid is always high in DONE, so ready alone completes the transfer.
        if (result_ready) begin
          result_valid_nxt = 1'b0;
`ifdef TDC_TIMEOUT_EN
          timeout_flag_nxt = 1'b0;
`endif
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cnt_clear    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      start_cnt    <= start_cnt_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      cnt_clear    <= cnt_clear_nxt;
      // Registered from the next state so busy tracks state with no extra cycle.
      busy         <= (state_nxt != IDLE);
    end
  end

`ifdef TDC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= timeout_flag_nxt;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: randomized transaction-level check of the TDC measurement sequencer.
// Latency: n/a.
// Backpressure: exercises result_ready stalls with stray arm/hit pulses.
module tb_tdc_meas_ctrl;

  localparam int TMO = 50;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        start_hit;
  logic        stop_hit;
  logic [31:0] count;
  logic        cnt_clear;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        timeout_flag;

  int checks;
  int errors;

  tdc_meas_ctrl #(
    .CNT_W (32)
`ifdef TDC_TIMEOUT_EN
    , .TIMEOUT (32'(TMO))
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .start_hit    (start_hit),
    .stop_hit     (stop_hit),
    .count        (count),
    .cnt_clear    (cnt_clear),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: the external coarse counter loads 1 after a cnt_clear cycle,
  // otherwise increments. Inputs change and outputs are sampled 1 after the edge.
  task automatic step();
    logic clr;
    clr = cnt_clear;
    @(posedge clk);
    #1;
    count = clr ? 32'd1 : count + 32'd1;
  endtask

  // One full measurement: idle noise, arm, armed noise, start, run noise,
  // stop after 'interval' counts, optional ready stall, transfer.
  task automatic measure(input int idle_gap, input int armed_gap, input int interval,
                         input int ready_delay, input bit preset_en,
                         input logic [31:0] preset, input bit simul);
    logic [31:0] s, e, exp;
    for (int i = 0; i < idle_gap; i++) begin
      start_hit = rbit();
      stop_hit  = rbit();
      step();
    end
    start_hit = 1'b0;
    stop_hit  = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(result_valid), 32'd0);

    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_clear", 32'(cnt_clear), 32'd1);
    check("arm_busy", 32'(busy), 32'd1);
    step();
    check("clear_pulse", 32'(cnt_clear), 32'd0);

    for (int i = 0; i < armed_gap; i++) begin
      stop_hit = rbit();
      arm      = rbit();
      step();
      check("armed_clear", 32'(cnt_clear), 32'd0);
    end
    stop_hit = 1'b0;
    arm      = 1'b0;
    check("armed_valid", 32'(result_valid), 32'd0);
    check("armed_busy", 32'(busy), 32'd1);

    if (preset_en) count = preset;
    s         = count;
    start_hit = 1'b1;
    stop_hit  = simul;
    step();
    start_hit = 1'b0;
    stop_hit  = 1'b0;

    for (int i = 1; i < interval; i++) begin
      start_hit = rbit();
      arm       = rbit();
      step();
    end
    start_hit = 1'b0;
    arm       = 1'b0;
    check("run_valid", 32'(result_valid), 32'd0);

    e        = count;
    exp      = e - s;
    stop_hit = 1'b1;
    step();
    stop_hit = 1'b0;
    check("result", result, exp);
    check("valid", 32'(result_valid), 32'd1);
    check("tflag", 32'(timeout_flag), 32'd0);

    result_ready = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      stop_hit  = rbit();
      start_hit = rbit();
      arm       = rbit();
      step();
      check("hold_result", result, exp);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_clear", 32'(cnt_clear), 32'd0);
    end
    stop_hit     = 1'b0;
    start_hit    = 1'b0;
    arm          = 1'b0;
    result_ready = 1'b1;
    step();
    check("xfer_valid", 32'(result_valid), 32'd0);
    check("xfer_busy", 32'(busy), 32'd0);
    check("keep_result", result, exp);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    arm          = 1'b0;
    start_hit    = 1'b0;
    stop_hit     = 1'b0;
    count        = 32'd0;
    result_ready = 1'b1;
    #12;
    check("rst_clear", 32'(cnt_clear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_tflag", 32'(timeout_flag), 32'd0);
    reset = 1'b0;

    // Basic interval 10 -> 110 (shortened below the timeout when it is built in).
`ifdef TDC_TIMEOUT_EN
    measure(1, 0, 30, 0, 1'b1, 32'd10, 1'b0);
`else
    measure(1, 0, 100, 0, 1'b1, 32'd10, 1'b0);
    measure(0, 2, 80, 1, 1'b0, 32'd0, 1'b0);
`endif
    // Wrap: FFFF_FFF0 -> 0000_0010.
    measure(0, 1, 32, 0, 1'b1, 32'hFFFF_FFF0, 1'b0);
    // Backpressure: 20 stalled cycles with stray pulses, then arm right after transfer.
    measure(2, 3, 17, 20, 1'b0, 32'd0, 1'b0);
    // Simultaneous start/stop in ARMED, stop 5 cycles later.
    measure(0, 0, 5, 0, 1'b0, 32'd0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      measure(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 40)), int'($urandom_range(0, 5)),
              ($urandom_range(0, 3) == 0), $urandom, rbit());
    end

    // Asynchronous reset in RUN.
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    start_hit = 1'b1;
    step();
    start_hit = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_clear", 32'(cnt_clear), 32'd0);
    check("arst_tflag", 32'(timeout_flag), 32'd0);
    #1 reset = 1'b0;
    measure(0, 1, 17, 2, 1'b0, 32'd0, 1'b0);

`ifdef TDC_TIMEOUT_EN
    // No stop: DONE once TMO counts have elapsed since the start sample.
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    start_hit = 1'b1;
    step();
    start_hit = 1'b0;
    repeat (TMO - 1) step();
    check("tmo_early", 32'(result_valid), 32'd0);
    result_ready = 1'b0;
    step();
    check("tmo_valid", 32'(result_valid), 32'd1);
    check("tmo_flag", 32'(timeout_flag), 32'd1);
    check("tmo_result", result, 32'hFFFF_FFFF);
    step();
    check("tmo_hold_flag", 32'(timeout_flag), 32'd1);
    result_ready = 1'b1;
    step();
    check("tmo_xfer_flag", 32'(timeout_flag), 32'd0);
    check("tmo_xfer_busy", 32'(busy), 32'd0);
    // Stop coinciding with the timeout threshold gives a normal result.
    measure(0, 0, TMO, 0, 1'b0, 32'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
